btb_update_ctrl: RTL and testbench

// - Sequences all accesses to the single-ported BTB array. Arbitrates the port between fetch-stage lookups and

---
 rtl/btb_update_ctrl_if.sv | 53 +++++
 rtl/btb_update_ctrl.sv | 176 +++++++++++++++++
 tb/tb_btb_update_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/btb_update_ctrl_if.sv
// Bundle of resolved-branch, fetch-arbitration and BTB-array signals for btb_update_ctrl.
// Optional statistics outputs are present only when BTB_STATS_EN is defined.
interface btb_update_ctrl_if #(
   parameter int INDEX_BITS = 3
);
   localparam int TAG_BITS = 15 - INDEX_BITS;

   logic                  res_valid;
   logic [15:0]           res_pc;
   logic [15:0]           res_target;
   logic                  res_taken;
   logic                  res_ready;

   logic                  fetch_req;
   logic                  fetch_grant;
   logic                  fetch_stall;

   logic                  btb_sel;
   logic [INDEX_BITS-1:0] btb_idx;
   logic                  btb_we;
   logic [TAG_BITS-1:0]   btb_wtag;
   logic [15:0]           btb_wtarget;
   logic [1:0]            btb_wpred;
   logic                  btb_rvalid;
   logic [TAG_BITS-1:0]   btb_rtag;
   logic [1:0]            btb_rpred;

`ifdef BTB_STATS_EN
   logic [15:0]           stat_updates;
   logic [15:0]           stat_allocs;
`endif

   // slave = the update controller, master = pipeline/fetch/array side
   modport slave (
      input  res_valid, res_pc, res_target, res_taken, fetch_req,
             btb_rvalid, btb_rtag, btb_rpred,
      output res_ready, fetch_grant, fetch_stall,
             btb_sel, btb_idx, btb_we, btb_wtag, btb_wtarget, btb_wpred
`ifdef BTB_STATS_EN
      , output stat_updates, stat_allocs
`endif
   );

   modport master (
      output res_valid, res_pc, res_target, res_taken, fetch_req,
             btb_rvalid, btb_rtag, btb_rpred,
      input  res_ready, fetch_grant, fetch_stall,
             btb_sel, btb_idx, btb_we, btb_wtag, btb_wtarget, btb_wpred
`ifdef BTB_STATS_EN
      , input stat_updates, stat_allocs
`endif
   );
endinterface

// File: rtl/btb_update_ctrl.sv
// Single-port BTB access sequencer: queues resolved branches and applies them as
// read-compare-write updates between fetch lookups. Define BTB_STATS_EN for hit/alloc counters.
module btb_update_ctrl #(
   parameter int INDEX_BITS = 3,
   parameter int FIFO_DEPTH = 4
) (
   input  logic               clk,
   input  logic               reset,
   btb_update_ctrl_if.slave   bus
);
   localparam int TAG_BITS = 15 - INDEX_BITS;
   localparam int PTR_BITS = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, READ, COMPARE, WRITE} state_t;

   typedef struct packed {
      logic [TAG_BITS-1:0]   tag;
      logic [INDEX_BITS-1:0] idx;
      logic [15:0]           target;
      logic                  taken;
   } entry_t;

   state_t                r_state;
   entry_t                r_fifo [FIFO_DEPTH];
   logic [PTR_BITS-1:0]   r_head;
   logic [PTR_BITS-1:0]   r_tail;
   logic [PTR_BITS:0]     r_count;

   logic                  r_btb_sel;
   logic                  r_btb_we;
   logic [INDEX_BITS-1:0] r_btb_idx;
   logic [TAG_BITS-1:0]   r_btb_wtag;
   logic [15:0]           r_btb_wtarget;
   logic [1:0]            r_btb_wpred;

   entry_t                w_head;
   entry_t                w_push_entry;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_hit;
   logic                  w_write_needed;
   logic [1:0]            w_next_pred;
   logic                  w_unused_pc0;

   assign w_full       = (r_count == (PTR_BITS+1)'(FIFO_DEPTH));
   assign w_empty      = (r_count == '0);
   assign w_push       = bus.res_valid && !w_full;
   assign w_push_entry = '{tag:    bus.res_pc[15:INDEX_BITS+1],
                           idx:    bus.res_pc[INDEX_BITS:1],
                           target: bus.res_target,
                           taken:  bus.res_taken};
   assign w_unused_pc0 = bus.res_pc[0];
   assign w_head       = r_fifo[r_head];

   // Array read data in COMPARE belongs to the address driven during READ.
   assign w_hit          = bus.btb_rvalid && (bus.btb_rtag == w_head.tag);
   assign w_write_needed = w_hit || w_head.taken;
   assign w_pop          = (r_state == WRITE) || ((r_state == COMPARE) && !w_write_needed);

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      w_next_pred = 2'b10;
      if (w_hit) begin
         if (w_head.taken)
            w_next_pred = (bus.btb_rpred == 2'b11) ? 2'b11 : bus.btb_rpred + 2'b01;
         else
            w_next_pred = (bus.btb_rpred == 2'b00) ? 2'b00 : bus.btb_rpred - 2'b01;
      end
   end

   // NOTE: queue storage is not reset; only the pointers and count decide what is valid.
   always_ff @(posedge clk) begin
      if (w_push) r_fifo[r_tail] <= w_push_entry;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_tail <= r_tail + 1'b1;
         if (w_pop)  r_head <= r_head + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= IDLE;
         r_btb_sel     <= 1'b0;
         r_btb_we      <= 1'b0;
         r_btb_idx     <= '0;
         r_btb_wtag    <= '0;
         r_btb_wtarget <= '0;
         r_btb_wpred   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               // A full queue takes the port away from fetch.
               if (!w_empty && (!bus.fetch_req || w_full)) begin
                  r_state   <= READ;
                  r_btb_sel <= 1'b1;
                  r_btb_idx <= w_head.idx;
               end
            end
            READ: r_state <= COMPARE;
            COMPARE: begin
               if (w_write_needed) begin
                  r_state       <= WRITE;
                  r_btb_we      <= 1'b1;
                  r_btb_wtag    <= w_head.tag;
                  r_btb_wtarget <= w_head.target;
                  r_btb_wpred   <= w_next_pred;
               end else begin
                  r_state   <= IDLE;
                  r_btb_sel <= 1'b0;
               end
            end
            WRITE: begin
               r_state   <= IDLE;
               r_btb_we  <= 1'b0;
               r_btb_sel <= 1'b0;
            end
            default: begin
               r_state   <= IDLE;
               r_btb_we  <= 1'b0;
               r_btb_sel <= 1'b0;
            end
         endcase
      end
   end

   assign bus.res_ready   = !w_full;
   assign bus.fetch_grant = (r_state == IDLE) && bus.fetch_req && !w_full;
   assign bus.fetch_stall = bus.fetch_req && !bus.fetch_grant;
   assign bus.btb_sel     = r_btb_sel;
   assign bus.btb_idx     = r_btb_idx;
   assign bus.btb_we      = r_btb_we;
   assign bus.btb_wtag    = r_btb_wtag;
   assign bus.btb_wtarget = r_btb_wtarget;
   assign bus.btb_wpred   = r_btb_wpred;

`ifdef BTB_STATS_EN
   logic        r_was_hit;
   logic [15:0] r_stat_updates;
   logic [15:0] r_stat_allocs;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_was_hit      <= 1'b0;
         r_stat_updates <= '0;
         r_stat_allocs  <= '0;
      end else begin
         if (r_state == COMPARE) r_was_hit <= w_hit;
         if (r_state == WRITE) begin
            if (r_was_hit) begin
               if (r_stat_updates != 16'hFFFF) r_stat_updates <= r_stat_updates + 16'd1;
            end else begin
               if (r_stat_allocs != 16'hFFFF) r_stat_allocs <= r_stat_allocs + 16'd1;
            end
         end
      end
   end

   assign bus.stat_updates = r_stat_updates;
   assign bus.stat_allocs  = r_stat_allocs;
`endif
endmodule

// File: tb/tb_btb_update_ctrl.sv
// Self-checking bench for btb_update_ctrl: directed vector table, multi-cycle corner sequences,
// and randomized traffic against a queue-plus-array reference model that also serves as BTB storage.
`timescale 1ns/1ps
module tb_btb_update_ctrl;
   localparam int IB    = 3;
   localparam int DEPTH = 4;
   localparam int TB    = 15 - IB;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   btb_update_ctrl_if #(.INDEX_BITS(IB)) bus ();
   btb_update_ctrl #(.INDEX_BITS(IB), .FIFO_DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference BTB contents; the array read port below serves the DUT from it.
   logic          ref_valid  [8];
   logic [TB-1:0] ref_tag    [8];
   logic [15:0]   ref_target [8];
   logic [1:0]    ref_pred   [8];
   logic [IB-1:0] fetch_idx;

   always @(posedge clk) begin : rd_port
      logic [IB-1:0] a;
      a = bus.btb_sel ? bus.btb_idx : fetch_idx;
      bus.btb_rvalid <= ref_valid[a];
      bus.btb_rtag   <= ref_tag[a];
      bus.btb_rpred  <= ref_pred[a];
   end

   task automatic quiet();
      bus.res_valid  = 1'b0;
      bus.res_pc     = 16'h0;
      bus.res_target = 16'h0;
      bus.res_taken  = 1'b0;
      bus.fetch_req  = 1'b0;
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 8; i++) begin
         ref_valid[i] = 1'b0; ref_tag[i] = '0; ref_target[i] = '0; ref_pred[i] = '0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      quiet();
      @(negedge clk);
      reset = 1'b0;
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      logic [15:0]   pc;
      logic [15:0]   target;
      logic          taken;
      logic          mv;
      logic [TB-1:0] mtag;
      logic [1:0]    mpred;
      logic          exp_we;
      logic [1:0]    exp_pred;
   } vec_t;

   vec_t vecs [9];

   task automatic push_one(input logic [15:0] pc, input logic [15:0] tgt, input logic tk);
      @(negedge clk);
      bus.res_valid  = 1'b1;
      bus.res_pc     = pc;
      bus.res_target = tgt;
      bus.res_taken  = tk;
      @(negedge clk);
      bus.res_valid  = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      logic [IB-1:0] idx;
      idx = v.pc[IB:1];
      ref_valid[idx] = v.mv;
      ref_tag[idx]   = v.mtag;
      ref_pred[idx]  = v.mpred;
      push_one(v.pc, v.target, v.taken);
      check({tag, ".k0_sel"}, bus.btb_sel, 1'b0);
      @(negedge clk);
      check({tag, ".read_sel"}, bus.btb_sel, 1'b1);
      check({tag, ".read_idx"}, bus.btb_idx, idx);
      check({tag, ".read_we"}, bus.btb_we, 1'b0);
      @(negedge clk);
      check({tag, ".cmp_we"}, bus.btb_we, 1'b0);
      @(negedge clk);
      check({tag, ".we"}, bus.btb_we, v.exp_we);
      check({tag, ".sel3"}, bus.btb_sel, v.exp_we);
      if (v.exp_we) begin
         check({tag, ".wtag"}, bus.btb_wtag, v.pc[15:IB+1]);
         check({tag, ".wtarget"}, bus.btb_wtarget, v.target);
         check({tag, ".wpred"}, bus.btb_wpred, v.exp_pred);
         @(negedge clk);
         check({tag, ".we_once"}, bus.btb_we, 1'b0);
         check({tag, ".idle_sel"}, bus.btb_sel, 1'b0);
      end
      check({tag, ".ready"}, bus.res_ready, 1'b1);
   endtask

   // ---------------- random-phase model ----------------
   typedef struct {
      logic [IB-1:0] idx;
      logic [TB-1:0] tag;
      logic [15:0]   target;
      logic          taken;
   } upd_t;

   upd_t          q[$];
   upd_t          push_e;
   logic          push_d, prev_sel, start_exp;
   int            burst_len, we_cnt, n_done;
   logic [IB-1:0] cap_idx;
   logic [TB-1:0] cap_tag;
   logic [15:0]   cap_target;
   logic [1:0]    cap_pred;

   task automatic finish_update();
      upd_t       e;
      logic       hit, do_wr;
      logic [1:0] np;
      int         p;
      if (q.size() == 0) begin
         check("rnd.pop_empty", 1'b1, 1'b0);
         return;
      end
      e     = q.pop_front();
      hit   = ref_valid[e.idx] && (ref_tag[e.idx] == e.tag);
      do_wr = hit || e.taken;
      p     = int'(ref_pred[e.idx]);
      if (!hit)        np = 2'b10;
      else if (e.taken) np = 2'(p >= 3 ? 3 : p + 1);
      else             np = 2'(p <= 0 ? 0 : p - 1);
      check("rnd.burst_len", burst_len, do_wr ? 3 : 2);
      check("rnd.we_count", we_cnt, do_wr ? 1 : 0);
      if (do_wr) begin
         check("rnd.widx", cap_idx, e.idx);
         check("rnd.wtag", cap_tag, e.tag);
         check("rnd.wtarget", cap_target, e.target);
         check("rnd.wpred", cap_pred, np);
         ref_valid[e.idx]  = 1'b1;
         ref_tag[e.idx]    = e.tag;
         ref_target[e.idx] = e.target;
         ref_pred[e.idx]   = np;
      end
      n_done++;
   endtask

   task automatic rand_cycle(input bit traffic, input bit fetch_heavy);
      logic [TB-1:0] t;
      logic [IB-1:0] ix;
      @(negedge clk);
      if (push_d) q.push_back(push_e);
      if (bus.btb_sel) begin
         if (!prev_sel) begin
            burst_len = 0;
            we_cnt    = 0;
            if (q.size() > 0) check("rnd.read_idx", bus.btb_idx, q[0].idx);
         end
         burst_len++;
         if (bus.btb_we) begin
            we_cnt++;
            cap_idx = bus.btb_idx; cap_tag = bus.btb_wtag;
            cap_target = bus.btb_wtarget; cap_pred = bus.btb_wpred;
         end
      end else begin
         check("rnd.we_idle", bus.btb_we, 1'b0);
         if (prev_sel) finish_update();
      end
      if (!prev_sel) check("rnd.start", bus.btb_sel, start_exp);
      check("rnd.ready", bus.res_ready, q.size() < DEPTH);
      prev_sel = bus.btb_sel;

      t  = TB'($urandom_range(1, 3));
      ix = IB'($urandom_range(0, 7));
      bus.res_valid  = traffic && ($urandom_range(0, 1) == 1);
      bus.res_pc     = {t, ix, 1'b0};
      bus.res_target = 16'($urandom);
      bus.res_taken  = 1'($urandom);
      bus.fetch_req  = traffic && ($urandom_range(0, 9) < (fetch_heavy ? 9 : 3));
      fetch_idx      = IB'($urandom);
      #1;
      check("rnd.grant", bus.fetch_grant,
            bus.fetch_req && !bus.btb_sel && (q.size() < DEPTH));
      check("rnd.stall", bus.fetch_stall,
            bus.fetch_req && !(!bus.btb_sel && (q.size() < DEPTH)));
      push_d    = bus.res_valid && bus.res_ready;
      push_e    = '{idx: ix, tag: t, target: bus.res_target, taken: bus.res_taken};
      start_exp = !bus.btb_sel && (q.size() > 0) && (!bus.fetch_req || q.size() == DEPTH);
   endtask

   initial begin
      vecs[0] = '{16'h0010, 16'h0040, 1'b1, 1'b0, 12'h000, 2'b00, 1'b1, 2'b10};
      vecs[1] = '{16'h0124, 16'h0200, 1'b1, 1'b1, 12'h012, 2'b11, 1'b1, 2'b11};
      vecs[2] = '{16'h0036, 16'h0300, 1'b0, 1'b1, 12'h003, 2'b00, 1'b1, 2'b00};
      vecs[3] = '{16'h0048, 16'h0400, 1'b0, 1'b0, 12'h004, 2'b00, 1'b0, 2'b00};
      vecs[4] = '{16'h005A, 16'h0500, 1'b1, 1'b1, 12'h005, 2'b01, 1'b1, 2'b10};
      vecs[5] = '{16'h006C, 16'h0600, 1'b0, 1'b1, 12'h006, 2'b10, 1'b1, 2'b01};
      vecs[6] = '{16'h007E, 16'h0700, 1'b1, 1'b1, 12'h0AB, 2'b11, 1'b1, 2'b10};
      vecs[7] = '{16'h0010, 16'h0800, 1'b0, 1'b1, 12'h001, 2'b11, 1'b1, 2'b10};
      vecs[8] = '{16'h0048, 16'h0900, 1'b0, 1'b1, 12'h005, 2'b01, 1'b0, 2'b00};

      reset = 1'b1;
      quiet();
      clear_mem();
      fetch_idx = '0;
      #1;
      check("rst.res_ready", bus.res_ready, 1'b1);
      check("rst.fetch_grant", bus.fetch_grant, 1'b0);
      check("rst.btb_sel", bus.btb_sel, 1'b0);
      check("rst.btb_we", bus.btb_we, 1'b0);
      check("rst.btb_idx", bus.btb_idx, 3'd0);
      check("rst.btb_wtag", bus.btb_wtag, 12'd0);
      check("rst.btb_wtarget", bus.btb_wtarget, 16'd0);
      check("rst.btb_wpred", bus.btb_wpred, 2'd0);
`ifdef BTB_STATS_EN
      check("rst.stat_updates", bus.stat_updates, 16'd0);
      check("rst.stat_allocs", bus.stat_allocs, 16'd0);
`endif
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Reset while the write strobe is up.
      do_reset();
      clear_mem();
      push_one(16'h0010, 16'h0040, 1'b1);
      repeat (3) @(negedge clk);
      check("rstw.we_before", bus.btb_we, 1'b1);
      #2 reset = 1'b1;
      #1;
      check("rstw.we_async", bus.btb_we, 1'b0);
      check("rstw.ready", bus.res_ready, 1'b1);
      check("rstw.sel", bus.btb_sel, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      bus.fetch_req = 1'b1;
      #1;
      check("rstw.grant", bus.fetch_grant, 1'b1);
      bus.fetch_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("rstw.fifo_empty", bus.btb_sel, 1'b0);
      end

      // Fill the queue while fetch holds the port.
      do_reset();
      clear_mem();
      bus.fetch_req = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         @(negedge clk);
         bus.res_valid  = 1'b1;
         bus.res_pc     = 16'(16'h0010 + 2 * i);
         bus.res_target = 16'(16'h1000 + i);
         bus.res_taken  = 1'b1;
         #1;
         check("full.grant_fill", bus.fetch_grant, 1'b1);
         check("full.ready_fill", bus.res_ready, 1'b1);
      end
      @(negedge clk);
      bus.res_valid = 1'b0;
      #1;
      check("full.ready0", bus.res_ready, 1'b0);
      check("full.grant0", bus.fetch_grant, 1'b0);
      check("full.stall", bus.fetch_stall, 1'b1);
      @(negedge clk);
      check("full.read_sel", bus.btb_sel, 1'b1);
      check("full.read_idx", bus.btb_idx, 3'd0);
      check("full.read_ready", bus.res_ready, 1'b0);
      check("full.read_stall", bus.fetch_stall, 1'b1);
      @(negedge clk);
      check("full.cmp_ready", bus.res_ready, 1'b0);
      @(negedge clk);
      check("full.we", bus.btb_we, 1'b1);
      check("full.wtarget", bus.btb_wtarget, 16'h1000);
      check("full.wr_ready", bus.res_ready, 1'b0);
      @(negedge clk);
      check("full.ready_pop", bus.res_ready, 1'b1);
      check("full.sel_pop", bus.btb_sel, 1'b0);
      #1;
      check("full.grant_again", bus.fetch_grant, 1'b1);

`ifdef BTB_STATS_EN
      do_reset();
      clear_mem();
      run_vec(vecs[0], "stat0");
      run_vec(vecs[6], "stat1");
      run_vec(vecs[1], "stat2");
      check("stat.updates", bus.stat_updates, 16'd1);
      check("stat.allocs", bus.stat_allocs, 16'd2);
`endif

      // Randomized traffic against the reference model.
      do_reset();
      for (int i = 0; i < 8; i++) begin
         ref_valid[i]  = 1'($urandom);
         ref_tag[i]    = TB'($urandom_range(1, 3));
         ref_target[i] = 16'($urandom);
         ref_pred[i]   = 2'($urandom);
      end
      q.delete();
      push_d = 1'b0; prev_sel = 1'b0; start_exp = 1'b0;
      burst_len = 0; we_cnt = 0; n_done = 0;
      for (int c = 0; c < 4000; c++) rand_cycle(1'b1, c[8]);
      for (int c = 0; c < 40; c++) rand_cycle(1'b0, 1'b0);
      check("rnd.drained", q.size(), 0);
      check("rnd.progress", n_done > 100, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
